// File: rtl/vx_rop_batch_agent.sv
// vx_rop_batch_agent: captures a warp, issues it as NUM_LANES-wide ROP requests, then commits it.
// Optional build macro VX_ROP_SKIP_EMPTY_EN: batches with an empty thread-mask slice are skipped.
module vx_rop_batch_agent #(
  parameter int THREAD_CNT = 8,
  parameter int NUM_LANES  = 2,
  parameter int DIM_BITS   = 11,
  parameter int DEPTH_BITS = 24,
  parameter int UUID_W     = 44,
  parameter int NW_W       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           exe_valid,
  output logic                           exe_ready,
  input  logic [UUID_W-1:0]              exe_uuid,
  input  logic [NW_W-1:0]                exe_wid,
  input  logic [THREAD_CNT-1:0]          exe_tmask,
  input  logic [THREAD_CNT*32-1:0]       exe_rs1,
  input  logic [THREAD_CNT*32-1:0]       exe_rs2,
  input  logic [THREAD_CNT*32-1:0]       exe_rs3,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [UUID_W-1:0]              req_uuid,
  output logic [NUM_LANES-1:0]           req_mask,
  output logic [NUM_LANES*DIM_BITS-1:0]  req_pos_x,
  output logic [NUM_LANES*DIM_BITS-1:0]  req_pos_y,
  output logic [NUM_LANES-1:0]           req_face,
  output logic [NUM_LANES*32-1:0]        req_color,
  output logic [NUM_LANES*DEPTH_BITS-1:0] req_depth,
  output logic                           commit_valid,
  input  logic                           commit_ready,
  output logic [UUID_W-1:0]              commit_uuid,
  output logic [NW_W-1:0]                commit_wid,
  output logic [THREAD_CNT-1:0]          commit_tmask
);
  // state  | meaning
  // IDLE   | waiting for a warp, exe_ready high
  // ISSUE  | presenting batch cur_b on req_*
  // COMMIT | all batches sent, holding commit_valid until commit_ready

  localparam int NB = THREAD_CNT / NUM_LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
`ifdef VX_ROP_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;
  state_t state;

  logic [BW-1:0]         bidx, cur_b, next_b;
  logic                  has_next;
  logic                  capture;
  logic [UUID_W-1:0]     uuid_q;
  logic [NW_W-1:0]       wid_q;
  logic [THREAD_CNT-1:0] tmask_q;
  logic                  face_q  [THREAD_CNT];
  logic [DIM_BITS-1:0]   pos_x_q [THREAD_CNT];
  logic [DIM_BITS-1:0]   pos_y_q [THREAD_CNT];
  logic [31:0]           color_q [THREAD_CNT];
  logic [DEPTH_BITS-1:0] depth_q [THREAD_CNT];
  logic                  unused_rs_bits;

  assign capture        = (state == IDLE) && exe_valid;
  assign unused_rs_bits = ^{exe_rs1, exe_rs3};

  always_ff @(posedge clk) begin
    if (capture) begin
      uuid_q  <= exe_uuid;
      wid_q   <= exe_wid;
      tmask_q <= exe_tmask;
      for (int t = 0; t < THREAD_CNT; t++) begin
        face_q[t]  <= exe_rs1[t*32];
        pos_x_q[t] <= exe_rs1[t*32+1 +: DIM_BITS];
        pos_y_q[t] <= exe_rs1[t*32+16 +: DIM_BITS];
        color_q[t] <= exe_rs2[t*32 +: 32];
        depth_q[t] <= exe_rs3[t*32 +: DEPTH_BITS];
      end
    end
  end

`ifdef VX_ROP_SKIP_EMPTY_EN
  // bidx is a lower bound; the presented batch is the first non-empty one at or above it
  logic cur_found;
  always_comb begin
    cur_b     = bidx;
    next_b    = bidx;
    has_next  = 1'b0;
    cur_found = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (!cur_found && (b >= int'(bidx)) && (tmask_q[b*NUM_LANES +: NUM_LANES] != '0)) begin
        cur_b     = BW'(b);
        cur_found = 1'b1;
      end else if (cur_found && !has_next && (tmask_q[b*NUM_LANES +: NUM_LANES] != '0)) begin
        next_b   = BW'(b);
        has_next = 1'b1;
      end
    end
  end
`else
  always_comb begin
    cur_b    = bidx;
    next_b   = bidx + BW'(1);
    has_next = (bidx != BW'(NB - 1));
  end
`endif

  always_comb begin
    req_mask  = '0;
    req_face  = '0;
    req_pos_x = '0;
    req_pos_y = '0;
    req_color = '0;
    req_depth = '0;
    for (int b = 0; b < NB; b++) begin
      if (cur_b == BW'(b)) begin
        req_mask = tmask_q[b*NUM_LANES +: NUM_LANES];
        for (int l = 0; l < NUM_LANES; l++) begin
          req_face[l]                           = face_q[b*NUM_LANES+l];
          req_pos_x[l*DIM_BITS +: DIM_BITS]     = pos_x_q[b*NUM_LANES+l];
          req_pos_y[l*DIM_BITS +: DIM_BITS]     = pos_y_q[b*NUM_LANES+l];
          req_color[l*32 +: 32]                 = color_q[b*NUM_LANES+l];
          req_depth[l*DEPTH_BITS +: DEPTH_BITS] = depth_q[b*NUM_LANES+l];
        end
      end
    end
  end

  assign req_uuid     = uuid_q;
  assign commit_uuid  = uuid_q;
  assign commit_wid   = wid_q;
  assign commit_tmask = tmask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bidx         <= '0;
      req_valid    <= 1'b0;
      commit_valid <= 1'b0;
      exe_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (exe_valid) begin
            bidx      <= '0;
            exe_ready <= 1'b0;
            if (SKIP && (exe_tmask == '0)) begin
              state        <= COMMIT;
              commit_valid <= 1'b1;
            end else begin
              state     <= ISSUE;
              req_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (req_ready) begin
            if (has_next) begin
              bidx <= next_b;
            end else begin
              state        <= COMMIT;
              req_valid    <= 1'b0;
              commit_valid <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (commit_ready) begin
            state        <= IDLE;
            commit_valid <= 1'b0;
            exe_ready    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vx_rop_batch_agent.md
VX_ROP_BATCH_AGENT -- requirements
Module: VX_rop_batch_agent

Interface
REQ-001 SHALL have parameters: THREAD_CNT, default 8, threads per warp; NUM_LANES, default 2, lanes per ROP request (divides THREAD_CNT); DIM_BITS, default 11, position width (≤15); DEPTH_BITS, default 24, depth width; UUID_W, default 44, uuid width; NW_W, default 4, warp-id width.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: exe_valid  in  1; exe_ready  out  1; exe_uuid  in  UUID_W; exe_wid  in  NW_W; exe_tmask  in  THREAD_CNT; exe_rs1/exe_rs2/exe_rs3  in  THREAD_CNT*32  per-thread operands.
REQ-004 SHALL have ports: req_valid  out  1; req_ready  in  1; req_uuid  out  UUID_W; req_mask  out  NUM_LANES; req_pos_x, req_pos_y  out  NUM_LANES*DIM_BITS; req_face  out  NUM_LANES; req_color  out  NUM_LANES*32; req_depth  out  NUM_LANES*DEPTH_BITS.
REQ-005 SHALL have ports: commit_valid  out  1; commit_ready  in  1; commit_uuid  out  UUID_W; commit_wid  out  NW_W; commit_tmask  out  THREAD_CNT.

Function
REQ-006 SHALL define NB = THREAD_CNT/NUM_LANES batches; batch b covers threads b*NUM_LANES .. b*NUM_LANES+NUM_LANES-1.
REQ-007 SHALL decode per thread: face=rs1[0], pos_x=rs1[1+:DIM_BITS], pos_y=rs1[16+:DIM_BITS], color=rs2[31:0], depth=rs3[DEPTH_BITS-1:0].
REQ-008 SHALL implement FSM IDLE, ISSUE, COMMIT; exe_ready=1 only in IDLE.
REQ-009 IDLE: on exe_valid&&exe_ready SHALL register full warp payload and go to ISSUE, or to COMMIT if no batch is to be issued (REQ-016).
REQ-010 ISSUE: req_valid SHALL be 1 from the cycle after capture; req_* SHALL present current batch from registers, stable while req_valid&&!req_ready.
REQ-011 On req_valid&&req_ready SHALL advance batch index to next batch to issue; after the last such batch SHALL go to COMMIT next cycle, req_valid deasserted that cycle.
REQ-012 Batch index SHALL be clog2(NB) bits (min 1), reset to 0 at each capture, never wrap past NB-1.
REQ-013 COMMIT: commit_valid=1 with captured uuid/wid/tmask; on commit_ready SHALL return to IDLE; next warp accepted no earlier than the following cycle.
REQ-014 req_mask SHALL equal the captured tmask slice of the current batch; req_uuid SHALL equal captured uuid.
REQ-015 Minimum latency: capture at cycle t, first req at t+1, commit_valid at t+1+k where k = batches issued (ready always high).
REQ-016 Batches issued SHALL be per Configuration; all-zero tmask with skipping enabled SHALL issue no request and go IDLE->COMMIT.
REQ-017 req_valid and commit_valid SHALL never be high in the same cycle.

Reset
REQ-018 Reset SHALL force state IDLE, batch index 0, req_valid=0, commit_valid=0, exe_ready=1 the cycle after.
REQ-019 Reset mid-ISSUE or mid-COMMIT SHALL discard the in-flight warp without emitting further req or commit.
REQ-020 Captured payload registers need not be reset.

Configuration
REQ-021 Macro VX_ROP_SKIP_EMPTY_EN defined: batches with all-zero mask slice SHALL be skipped (no req issued, zero cycles spent).
REQ-022 Macro undefined: all NB batches SHALL be issued in order, including zero-mask batches; commit always follows NB req handshakes.

Verification
REQ-023 Defaults, tmask=8'hFF, ready high: req at t+1..t+4, masks 2'b11 each, commit_valid at t+5; commit_ready -> IDLE at t+6.
REQ-024 Skip enabled, tmask=8'b0011_0000: exactly one req (batch 2, mask 2'b11, thread 4/5 data), then commit; skip disabled: 4 reqs, masks 00,00,11,00.
REQ-025 Back-pressure: req_ready low 3 cycles on batch 1 -> req_* stable, batch index unchanged, exe_ready=0 throughout.
REQ-026 Skip enabled, tmask=0: no req_valid, commit_valid at t+1, commit_tmask=0.
REQ-027 rs1=32'h0005_0007 lane 0 -> face=1, pos_x=3, pos_y=5; rs3=32'hAB12_3456 -> depth=24'h123456.
REQ-028 Reset asserted during batch 2 -> next cycle req_valid=0, commit_valid=0, exe_ready=1; no commit for that warp.
